// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences the shared memory, ALU, register file and PC, 2-5 cycles per instruction.
// Memory states stall on mem_ready and abort to FETCH with mem_err after MEM_TIMEOUT waiting cycles.
module mc_control_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    IEXEC  = 4'd10,
    IWB    = 4'd11
  } stateT;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSource;
  } ctrlT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  // Timeout fires on the MEM_TIMEOUT-th waiting cycle, when the counter still shows one less.
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  stateT             stateQ;
  stateT             stateD;
  ctrlT              ctrl;
  logic [WAIT_W-1:0] waitCnt;
  logic              memState;
  logic              timeoutHit;
  logic              memErrD;
  logic              illegalD;
  logic              retire;

  assign timeoutHit = (MEM_TIMEOUT != 0) && !mem_ready && (waitCnt == TO_LAST);

  always_comb begin
    stateD   = stateQ;
    ctrl     = '0;
    memState = 1'b0;
    memErrD  = 1'b0;
    illegalD = 1'b0;
    retire   = 1'b0;
    case (stateQ)
      FETCH: begin
        memState      = 1'b1;
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = 2'b01;
        if (mem_ready) begin
          ctrl.irWrite = 1'b1;
          ctrl.pcWrite = 1'b1;
          stateD       = DECODE;
        end else if (timeoutHit) begin
          memErrD = 1'b1;
          stateD  = FETCH;
        end
      end
      DECODE: begin
        ctrl.aluSrcB = 2'b11;
        case (Op)
          OP_RTYPE:         stateD = EXEC;
          OP_LW, OP_SW:     stateD = MEMADR;
          OP_BEQ:           stateD = BRANCH;
          OP_J:             stateD = JUMP;
          OP_ADDI, OP_ANDI: stateD = IEXEC;
          default: begin
            illegalD = 1'b1;
            stateD   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
        stateD       = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memState     = 1'b1;
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
        if (mem_ready) begin
          stateD = MEMWB;
        end else if (timeoutHit) begin
          memErrD = 1'b1;
          stateD  = FETCH;
        end
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memToReg = 1'b1;
        retire        = 1'b1;
        stateD        = FETCH;
      end
      MEMWR: begin
        memState      = 1'b1;
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          stateD = FETCH;
        end else if (timeoutHit) begin
          memErrD = 1'b1;
          stateD  = FETCH;
        end
      end
      EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = 3'b001;
        stateD       = RWB;
      end
      RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
        retire        = 1'b1;
        stateD        = FETCH;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = 3'b010;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = 2'b01;
        retire           = 1'b1;
        stateD           = FETCH;
      end
      JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = 2'b10;
        retire        = 1'b1;
        stateD        = FETCH;
      end
      IEXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
        ctrl.aluOp   = (Op == OP_ANDI) ? 3'b011 : 3'b000;
        stateD       = IWB;
      end
      IWB: begin
        ctrl.regWrite = 1'b1;
        retire        = 1'b1;
        stateD        = FETCH;
      end
      default: stateD = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= FETCH;
    end else begin
      stateQ <= stateD;
    end
  end

  // Any cycle that is not a stalled memory wait restarts the count, so each memory state entry starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (memState && !mem_ready && !memErrD) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end else begin
      waitCnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign IRWrite     = ctrl.irWrite;
  assign MemToReg    = ctrl.memToReg;
  assign RegDst      = ctrl.regDst;
  assign RegWrite    = ctrl.regWrite;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign ALUOp       = ctrl.aluOp;
  assign PCSource    = ctrl.pcSource;
  assign state       = stateQ;
  assign illegal_op  = illegalD;
  assign mem_err     = memErrD;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class, memory stalls, timeout and mid-instruction reset.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ILL  = 6'b111111;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Op;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic [3:0]  state;
  logic        illegal_op;
  logic        mem_err;
  logic [31:0] instret;

  int nChecks = 0;
  int nFails  = 0;
  int nWr, nBr, nJ, nErr, nIrw;

  logic [5:0] opTab  [10] = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_BEQ, OP_BEQ, OP_BEQ, OP_J, OP_J, OP_J};
  int         expTab [10] = '{0, 1, 2, 5, 0, 1, 8, 0, 1, 9};

  mc_control_fsm #(.CNT_W(32), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
    .mem_err(mem_err), .instret(instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed no finish, required finish before 50000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic setIn(input logic r, input logic [5:0] op);
    mem_ready = r;
    Op        = op;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; Op = OP_R;
    #2;
    chk("rst_state", {28'd0, state}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    chk("rst_memerr", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // andi: FETCH, DECODE, IEXEC, IWB
    setIn(1'b1, OP_ANDI);
    chk("andi_fetch_state", {28'd0, state}, 32'd0);
    chk("andi_fetch_irw", {31'd0, IRWrite}, 32'd1);
    chk("andi_fetch_pcw", {31'd0, PCWrite}, 32'd1);
    chk("andi_fetch_srcb", {30'd0, ALUSrcB}, 32'd1);
    chk("andi_fetch_memrd", {31'd0, MemRead}, 32'd1);
    tick(); setIn(1'b1, OP_ANDI);
    chk("andi_dec_state", {28'd0, state}, 32'd1);
    chk("andi_dec_srcb", {30'd0, ALUSrcB}, 32'd3);
    chk("andi_dec_irw", {31'd0, IRWrite}, 32'd0);
    tick(); setIn(1'b1, OP_ANDI);
    chk("andi_iexec_state", {28'd0, state}, 32'd10);
    chk("andi_iexec_aluop", {29'd0, ALUOp}, 32'd3);
    chk("andi_iexec_srcb", {30'd0, ALUSrcB}, 32'd2);
    tick(); setIn(1'b1, OP_ANDI);
    chk("andi_iwb_state", {28'd0, state}, 32'd11);
    chk("andi_iwb_regw", {31'd0, RegWrite}, 32'd1);
    chk("andi_iwb_regdst", {31'd0, RegDst}, 32'd0);
    tick(); setIn(1'b1, OP_R);
    chk("andi_done_state", {28'd0, state}, 32'd0);
    chk("andi_instret", instret, 32'd1);

    // R-type: 0,1,6,7,0 with mem_ready ignored outside memory states
    tick(); setIn(1'b0, OP_R);
    chk("r_dec_state", {28'd0, state}, 32'd1);
    chk("r_dec_regw", {31'd0, RegWrite}, 32'd0);
    tick(); setIn(1'b0, OP_R);
    chk("r_exec_state", {28'd0, state}, 32'd6);
    chk("r_exec_aluop", {29'd0, ALUOp}, 32'd1);
    chk("r_exec_regw", {31'd0, RegWrite}, 32'd0);
    tick(); setIn(1'b0, OP_R);
    chk("r_rwb_state", {28'd0, state}, 32'd7);
    chk("r_rwb_regw", {31'd0, RegWrite}, 32'd1);
    chk("r_rwb_regdst", {31'd0, RegDst}, 32'd1);
    tick(); setIn(1'b1, OP_LW);
    chk("r_done_state", {28'd0, state}, 32'd0);
    chk("r_instret", instret, 32'd2);

    // lw with three stall cycles in MEMRD: 8 cycles total
    tick(); setIn(1'b1, OP_LW);
    chk("lw_dec_state", {28'd0, state}, 32'd1);
    tick(); setIn(1'b1, OP_LW);
    chk("lw_memadr_state", {28'd0, state}, 32'd2);
    chk("lw_memadr_srca", {31'd0, ALUSrcA}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); setIn(1'b0, OP_LW);
      chk("lw_memrd_wait_state", {28'd0, state}, 32'd3);
      chk("lw_memrd_iord", {31'd0, IorD}, 32'd1);
    end
    tick(); setIn(1'b1, OP_LW);
    chk("lw_memrd_ready_state", {28'd0, state}, 32'd3);
    chk("lw_memrd_instret", instret, 32'd2);
    tick(); setIn(1'b0, OP_LW);
    chk("lw_memwb_state", {28'd0, state}, 32'd4);
    chk("lw_memwb_m2r", {31'd0, MemToReg}, 32'd1);
    chk("lw_memwb_regw", {31'd0, RegWrite}, 32'd1);
    tick(); setIn(1'b1, OP_SW);
    chk("lw_done_state", {28'd0, state}, 32'd0);
    chk("lw_instret", instret, 32'd3);

    // sw, beq, j back-to-back
    nWr = 0; nBr = 0; nJ = 0;
    for (int i = 0; i < 10; i++) begin
      setIn(1'b1, opTab[i]);
      chk("swbj_state", {28'd0, state}, expTab[i]);
      nWr += int'(MemWrite);
      if (PCWriteCond && ALUOp == 3'b010) nBr++;
      if (PCWrite && PCSource == 2'b10) nJ++;
      tick();
    end
    setIn(1'b1, OP_ILL);
    chk("swbj_memwrite_count", nWr, 32'd1);
    chk("swbj_branch_count", nBr, 32'd1);
    chk("swbj_jump_count", nJ, 32'd1);
    chk("swbj_instret", instret, 32'd6);
    chk("ill_fetch_flag", {31'd0, illegal_op}, 32'd0);

    // illegal opcode
    tick(); setIn(1'b1, OP_ILL);
    chk("ill_dec_state", {28'd0, state}, 32'd1);
    chk("ill_dec_flag", {31'd0, illegal_op}, 32'd1);
    tick(); setIn(1'b0, OP_R);
    chk("ill_done_state", {28'd0, state}, 32'd0);
    chk("ill_done_flag", {31'd0, illegal_op}, 32'd0);
    chk("ill_instret", instret, 32'd6);

    // FETCH timeout: mem_err on the 15th waiting cycle
    nErr = 0; nIrw = 0;
    for (int c = 1; c <= 15; c++) begin
      setIn(1'b0, OP_R);
      nErr += int'(mem_err);
      nIrw += int'(IRWrite);
      if (c == 15) chk("to_memerr_c15", {31'd0, mem_err}, 32'd1);
      tick();
    end
    setIn(1'b0, OP_R);
    chk("to_state_after", {28'd0, state}, 32'd0);
    chk("to_memerr_after", {31'd0, mem_err}, 32'd0);
    chk("to_err_count", nErr, 32'd1);
    chk("to_irw_count", nIrw, 32'd0);

    // Ready on the 15th cycle wins over the timeout
    nErr = 0;
    for (int c = 1; c <= 15; c++) begin
      setIn(c == 15, OP_LW);
      nErr += int'(mem_err);
      if (c == 15) chk("rdy15_irw", {31'd0, IRWrite}, 32'd1);
      tick();
    end
    setIn(1'b1, OP_LW);
    chk("rdy15_err_count", nErr, 32'd0);
    chk("rdy15_dec_state", {28'd0, state}, 32'd1);
    tick(); setIn(1'b1, OP_LW);
    chk("rst_memadr_state", {28'd0, state}, 32'd2);
    tick(); setIn(1'b0, OP_LW);
    chk("rst_memrd_state", {28'd0, state}, 32'd3);

    // Asynchronous reset in the middle of MEMRD
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", {28'd0, state}, 32'd0);
    chk("mid_rst_instret", instret, 32'd0);
    chk("mid_rst_memwrite", {31'd0, MemWrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    setIn(1'b1, OP_R);
    chk("post_rst_state", {28'd0, state}, 32'd0);
    chk("post_rst_irw", {31'd0, IRWrite}, 32'd1);
    chk("post_rst_pcw", {31'd0, PCWrite}, 32'd1);
    tick(); setIn(1'b1, OP_R);
    chk("post_rst_dec_state", {28'd0, state}, 32'd1);
    chk("post_rst_regw", {31'd0, RegWrite}, 32'd0);
    chk("post_rst_instret", instret, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit: a Moore-style FSM that sequences the shared ALU, register file, instruction/data memory and PC over several cycles per instruction.
- Replaces the single-cycle decoder when the datapath shares one memory and one ALU.
- Supports R-type, lw, sw, beq, j, addi and andi.
- Handles a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in any memory state before aborting; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Op  input  6  opcode field of the instruction register (IR[31:26]), valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zero (datapath ANDs it with Zero).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemToReg  output  1  write-back select: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  destination select: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  output  3  ALU operation: 000 = add, 001 = funct-decoded (R-type), 010 = subtract, 011 = and.
- PCSource  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state, for debug.
- illegal_op  output  1  one-cycle pulse on an unsupported opcode.
- mem_err  output  1  one-cycle pulse on a memory timeout.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
Reset and output rules:
- rst_n low, asynchronously: state = FETCH (0), instret = 0, wait counter = 0, illegal_op = 0, mem_err = 0.
- All control outputs are decoded from state; they read 0 except the FETCH defaults below.
- Reset mid-instruction aborts it with no write strobe afterwards; instret is not incremented.

State encodings:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11.
- Codes 12-15 are unreachable; if entered they go to FETCH next cycle with all outputs 0.

Per-state outputs and transitions:
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 000, PCSource = 00. IRWrite and PCWrite = 1 only in the cycle mem_ready = 1, then go to DECODE; otherwise hold.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 000 (branch target into ALUOut). Next state by Op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 or 001100 -> IEXEC
  - any other -> FETCH, with illegal_op pulsed in the DECODE cycle.
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000. Go to MEMRD if Op = 100011, else MEMWR.
- MEMRD: MemRead = 1, IorD = 1; hold until mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0; then FETCH; instret increments.
- MEMWR: MemWrite = 1, IorD = 1; hold until mem_ready, then FETCH; instret increments on the mem_ready cycle.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001; then RWB.
- RWB: RegWrite = 1, RegDst = 1, MemToReg = 0; then FETCH; instret increments.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 010, PCWriteCond = 1, PCSource = 01; then FETCH; instret increments.
- JUMP: PCWrite = 1, PCSource = 10; then FETCH; instret increments.
- IEXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 000 for addi or 011 for andi; then IWB.
- IWB: RegWrite = 1, RegDst = 0, MemToReg = 0; then FETCH; instret increments.

Memory wait and timeout:
- Wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle mem_ready = 0 in those states.
- If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: pulse mem_err, go to FETCH, no IRWrite/PCWrite/RegWrite.
- mem_ready = 1 in the same cycle as the timeout wins: the access completes normally and mem_err stays 0.
- mem_ready is ignored in all non-memory states.

Other rules:
- instret wraps from all-ones to 0 silently.
- Latencies with mem_ready tied to 1: R/addi/andi 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.

Test Plan:
- rst_n = 0 mid-MEMRD, release -> state = 0, instret = 0; with mem_ready = 1, IRWrite = 1 and PCWrite = 1 in FETCH on the first cycle after release.
- mem_ready = 1, Op = 000000 -> states 0, 1, 6, 7, 0; RegWrite = 1 and RegDst = 1 only in state 7; ALUOp = 001 in state 6; instret = 1.
- Op = 100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with MemToReg = 1; total 8 cycles; instret increments once.
- Op = 101011 then 000100 then 000010 back-to-back -> MemWrite = 1 exactly once, PCWriteCond = 1 with ALUOp = 010 once, PCWrite = 1 with PCSource = 10 once; instret = 3.
- Op = 111111 -> illegal_op = 1 for one cycle in DECODE, returns to FETCH, instret unchanged.
- MEM_TIMEOUT = 15, mem_ready held 0 in FETCH -> mem_err pulses after 15 cycles, state re-enters FETCH, IRWrite never 1; repeat with mem_ready = 1 on the 15th cycle -> no mem_err, goes to DECODE.
